// File: rtl/regfile_pkg.sv
// Shared constants and types for the multiport integer register file.
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned AW_DEF    = $clog2(NREGS_DEF);

  localparam int unsigned ZERO_REG = 0;

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard for in-flight writebacks, with a running busy count.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_addr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  output logic [NREGS-1:0] busy,
  output logic [AW:0]      busy_cnt
);

  localparam int unsigned CW = AW + 1;

  logic [NREGS-1:0] busy_d, busy_q;
  logic [AW:0]      busy_cnt_d, busy_cnt_q;
  logic             iss_ok, wr_ok, cnt_inc, cnt_dec;

  assign iss_ok = iss_en && (iss_addr != AW'(ZERO_REG));
  assign wr_ok  = wr_en && (wr_addr != AW'(ZERO_REG));

  // Issue beats writeback on the same register: the newer instruction still owns it.
  assign cnt_inc = iss_ok && !busy_q[iss_addr];
  assign cnt_dec = wr_ok && busy_q[wr_addr] && !(iss_ok && (iss_addr == wr_addr));

  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NREGS; r++) begin
      if (iss_ok && (iss_addr == AW'(r))) begin
        busy_d[r] = 1'b1;
      end else if (wr_ok && (wr_addr == AW'(r))) begin
        busy_d[r] = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
    busy_cnt_d = busy_cnt_q + CW'(cnt_inc) - CW'(cnt_dec);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy     = busy_q;
  assign busy_cnt = busy_cnt_q;

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised integer register file: NRD combinational read ports, one write port,
// optional write-to-read bypass and a busy scoreboard for outstanding writebacks.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int unsigned     XLEN      = XLEN_DEF,
  parameter int unsigned     NREGS     = NREGS_DEF,
  parameter int unsigned     NRD       = 2,
  parameter int unsigned     BYPASS    = 1,
  parameter logic [XLEN-1:0] RESET_VAL = '0,
  parameter int unsigned     AW        = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  output logic [AW:0]         busy_cnt
);

  logic [XLEN-1:0]  regs_d [NREGS];
  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy;

  always_comb begin
    regs_d = regs_q;
    if (wr_en && (wr_addr != AW'(ZERO_REG))) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  // Entry 0 is reset to zero and never written, so it reads as zero regardless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= (i == 0) ? '0 : RESET_VAL;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .busy     (busy),
    .busy_cnt (busy_cnt)
  );

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] addr;
    logic          is_zero;
    logic          byp;

    assign addr    = rd_addr[k*AW +: AW];
    assign is_zero = (addr == AW'(ZERO_REG));
    assign byp     = (BYPASS != 0) && wr_en && (wr_addr == addr);

    assign rd_data[k*XLEN +: XLEN] = is_zero ? '0 : (byp ? wr_data : regs_q[addr]);
    // A forwarded write retires the pending writer as far as the reader is concerned.
    assign rd_busy[k] = !is_zero && busy[addr] && !byp;
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed self-checking bench: one bypassing and one non-bypassing instance share stimulus.
module tb_regfile_multiport;
  import regfile_pkg::*;

  localparam reg_data_t RV0 = 32'hC0FF_EE00;
  localparam reg_data_t RV1 = 32'h5A5A_5A5A;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic        wr_en;
  reg_addr_t   wr_addr;
  reg_data_t   wr_data;
  logic        iss_en;
  reg_addr_t   iss_addr;
  logic [63:0] rd_data0, rd_data1;
  logic [1:0]  rd_busy0, rd_busy1;
  logic [5:0]  busy_cnt0, busy_cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_multiport #(
    .XLEN (32), .NREGS (32), .NRD (2), .BYPASS (1), .RESET_VAL (RV0)
  ) u_dut_byp (
    .clk (clk), .rst (rst), .rd_addr (rd_addr), .rd_data (rd_data0), .rd_busy (rd_busy0),
    .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data), .iss_en (iss_en),
    .iss_addr (iss_addr), .busy_cnt (busy_cnt0)
  );

  regfile_multiport #(
    .XLEN (32), .NREGS (32), .NRD (2), .BYPASS (0), .RESET_VAL (RV1)
  ) u_dut_nobyp (
    .clk (clk), .rst (rst), .rd_addr (rd_addr), .rd_data (rd_data1), .rd_busy (rd_busy1),
    .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data), .iss_en (iss_en),
    .iss_addr (iss_addr), .busy_cnt (busy_cnt1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {5'(a1), 5'(a0)};
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; iss_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0;
    #1;
    check("reset_cnt_byp", 64'(busy_cnt0), 64'd0);
    check("reset_cnt_nobyp", 64'(busy_cnt1), 64'd0);
    tick();
    rst = 1'b0;

    // 1: reset contents on both ports
    for (int a = 0; a < 32; a++) begin
      set_rd(a, 31 - a);
      check("reset_p0_byp", 64'(rd_data0[31:0]), (a == 0) ? 64'd0 : 64'(RV0));
      check("reset_p1_byp", 64'(rd_data0[63:32]), (a == 31) ? 64'd0 : 64'(RV0));
      check("reset_p0_nobyp", 64'(rd_data1[31:0]), (a == 0) ? 64'd0 : 64'(RV1));
      check("reset_busy", 64'({rd_busy1, rd_busy0}), 64'd0);
    end

    // 2: bypass versus array-only read of a same-cycle write
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
    set_rd(5, 6);
    check("byp_before_edge", 64'(rd_data0[31:0]), 64'hDEAD_BEEF);
    check("nobyp_before_edge", 64'(rd_data1[31:0]), 64'(RV1));
    check("byp_other_port", 64'(rd_data0[63:32]), 64'(RV0));
    tick();
    idle();
    #1;
    check("byp_after_edge", 64'(rd_data0[31:0]), 64'hDEAD_BEEF);
    check("nobyp_after_edge", 64'(rd_data1[31:0]), 64'hDEAD_BEEF);

    // 3: x0 ignores writes and is never forwarded
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h0000_1234;
    set_rd(0, 0);
    check("x0_fwd_blocked", rd_data0, 64'd0);
    tick();
    idle();
    #1;
    check("x0_after_write_byp", rd_data0, 64'd0);
    check("x0_after_write_nobyp", rd_data1, 64'd0);
    check("x0_write_cnt", 64'(busy_cnt0), 64'd0);

    // 4: issue/writeback bookkeeping
    iss_en = 1'b1; iss_addr = 5'd3;
    tick();
    iss_addr = 5'd7;
    tick();
    idle();
    set_rd(3, 7);
    check("two_issued_cnt", 64'(busy_cnt0), 64'd2);
    check("two_issued_busy", 64'(rd_busy0), 64'b11);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
    #1;
    check("busy_masked_by_byp", 64'(rd_busy0), 64'b10);
    check("busy_not_masked_nobyp", 64'(rd_busy1), 64'b11);
    tick();
    idle();
    #1;
    check("wb_x3_cnt", 64'(busy_cnt0), 64'd1);
    check("wb_x3_busy", 64'(rd_busy1), 64'b10);
    iss_en = 1'b1; iss_addr = 5'd9;
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h77;
    tick();
    idle();
    set_rd(9, 7);
    check("swap_cnt", 64'(busy_cnt0), 64'd1);
    check("swap_busy", 64'(rd_busy0), 64'b01);
    check("swap_data_x7", 64'(rd_data1[63:32]), 64'h77);

    // 5: issue and writeback to the same register in one cycle
    iss_en = 1'b1; iss_addr = 5'd4;
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h44;
    tick();
    idle();
    set_rd(4, 9);
    check("iss_wr_same_cnt", 64'(busy_cnt0), 64'd2);
    check("iss_wr_same_busy", 64'(rd_busy1), 64'b11);
    check("iss_wr_same_data", 64'(rd_data1[31:0]), 64'h44);
    iss_en = 1'b1; iss_addr = 5'd9;
    tick();
    idle();
    #1;
    check("reissue_busy_cnt", 64'(busy_cnt0), 64'd2);
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'hAA;
    tick();
    idle();
    set_rd(10, 9);
    check("wr_not_busy_cnt", 64'(busy_cnt1), 64'd2);
    check("wr_not_busy_busy", 64'(rd_busy0), 64'b10);
    check("wr_not_busy_data", 64'(rd_data1[31:0]), 64'hAA);
    iss_en = 1'b1; iss_addr = 5'd0;
    tick();
    idle();
    #1;
    check("iss_x0_ignored", 64'(busy_cnt0), 64'd2);

    // 6: asynchronous reset mid-stream with a pending write and issue
    iss_en = 1'b1; iss_addr = 5'd11;
    tick();
    iss_addr = 5'd12;
    tick();
    #1;
    check("pre_rst_cnt", 64'(busy_cnt0), 64'd4);
    iss_addr = 5'd14;
    wr_en = 1'b1; wr_addr = 5'd13; wr_data = 32'h1313;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_cnt_byp", 64'(busy_cnt0), 64'd0);
    check("async_rst_cnt_nobyp", 64'(busy_cnt1), 64'd0);
    set_rd(5, 4);
    check("async_rst_x5", 64'(rd_data1[31:0]), 64'(RV1));
    check("async_rst_x4", 64'(rd_data0[63:32]), 64'(RV0));
    tick();
    idle();
    rst = 1'b0;
    set_rd(13, 14);
    check("pending_wr_dropped_byp", 64'(rd_data0[31:0]), 64'(RV0));
    check("pending_wr_dropped_nobyp", 64'(rd_data1[31:0]), 64'(RV1));
    check("pending_iss_dropped", 64'({rd_busy1, rd_busy0}), 64'd0);
    check("post_rst_cnt", 64'(busy_cnt0), 64'd0);

    // Normal operation resumes after reset
    wr_en = 1'b1; wr_addr = 5'd13; wr_data = 32'hCAFE_F00D;
    tick();
    idle();
    #1;
    check("post_rst_write", 64'(rd_data1[31:0]), 64'hCAFE_F00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
- Parametrised successor to the core's integer register file.
- Generalises data width, register count and number of read ports.
- Adds asynchronous reset, optional write-to-read bypass, and a per-register busy scoreboard for in-flight writebacks.
- Sits between decode/issue (reads and busy marking) and writeback (write port) in the pipelined RISC-V core.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers (power of 2, >=2); register 0 hard-wired to zero.
- NRD, 2, number of combinational read ports (1..4).
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads; 0 = reads see array contents only.
- RESET_VAL, 0, value loaded into registers 1..NREGS-1 on reset.
- AW, $clog2(NREGS), address width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- rd_addr  in  NRD*AW  packed read addresses; port k at bits [k*AW +: AW].
- rd_data  out  NRD*XLEN  packed read data; port k at [k*XLEN +: XLEN].
- rd_busy  out  NRD  port k's register has an outstanding write.
- wr_en  in  1  writeback enable.
- wr_addr  in  AW  writeback register.
- wr_data  in  XLEN  writeback data.
- iss_en  in  1  mark iss_addr busy (instruction issued with destination).
- iss_addr  in  AW  destination being marked.
- busy_cnt  out  AW+1  number of registers currently busy.

Behaviour:
- Reset (async assert, sync-safe deassert by system):
  - regs[1..NREGS-1] = RESET_VAL.
  - All busy bits = 0; busy_cnt = 0.
  - rd_busy = 0 for every port.
  - rd_data reflects reset contents combinationally.
- Reset mid-operation: pending writes and issues in that cycle are discarded; no partial update.
- Read: rd_data[k] combinational, zero-cycle latency.
  - Address 0 -> 0 always.
  - Else, if BYPASS=1 and wr_en and wr_addr==rd_addr[k] -> wr_data.
  - Else regs[rd_addr[k]].
- Write:
  - At posedge, if wr_en and wr_addr!=0, regs[wr_addr] <= wr_data.
  - Writes to address 0 are ignored, with no side effects.
- Scoreboard (per register r, r!=0), at posedge:
  - Set if iss_en and iss_addr==r.
  - Else clear if wr_en and wr_addr==r.
  - Else hold.
- Scoreboard boundary cases:
  - Simultaneous issue and write to the same r: busy remains 1, because the newer issue wins; data is still written.
  - Issue to r already busy: stays busy; no counting of multiple outstanding writers.
  - Write to r not busy: data written, busy stays 0, busy_cnt unchanged.
  - iss_addr==0: ignored.
- rd_busy[k] = busy[rd_addr[k]] AND NOT (BYPASS and wr_en and wr_addr==rd_addr[k]); forced 0 for address 0.
- busy_cnt update: +1 on a set of a clear bit, -1 on a clear of a set bit, net on simultaneous set of x and clear of y (x!=y).
  - Range 0..NREGS-1; never wraps.
  - Must equal popcount(busy) at all times.
- Multiple read ports may address the same register; all return identical values.

Decomposition:
- Package regfile_pkg:
  - Default XLEN, NREGS, AW constants.
  - Typedefs reg_addr_t and reg_data_t.
  - Constant ZERO_REG = 0.
- Sub-module regfile_scoreboard:
  - Owns the busy bits, busy_cnt and their set/clear priority.
  - Exposes the busy vector to the parent for rd_busy generation.
- The data array and read muxing remain in regfile_multiport.

Test Plan:
1. Reset then read all registers on every port -> x0=0, x1..x31=RESET_VAL; busy_cnt=0, rd_busy=0.
2. Write 0xDEADBEEF to x5 with rd_addr[0]=5 in the same cycle:
   - BYPASS=1 -> rd_data[0]=0xDEADBEEF before the edge.
   - BYPASS=0 -> old value before the edge, 0xDEADBEEF after.
3. Write 0x1234 to x0, then read x0 on both ports -> 0; busy_cnt unchanged.
4. Issue x3, then issue x7 -> busy_cnt=2.
   - Write x3 -> busy_cnt=1, rd_busy for x3=0, x7 still busy.
   - Same-cycle issue x9 and write x7 -> busy_cnt stays 1.
5. Issue x4 and write x4 in the same cycle -> data written, x4 busy remains 1, busy_cnt+1.
6. Assert rst asynchronously mid-stream with several busy registers and a write pending -> immediately busy_cnt=0 and registers=RESET_VAL; pending write not applied.
